// File: rtl/md_defs.sv
// Shared definitions for the E-stage multiply/divide unit: op and state encodings,
// default latencies, and the behavioural arithmetic used to form pending results.
package md_defs;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned CNT_W           = 5;
    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } md_state_e;

    // Result waiting for the end of the busy window; valid=0 means leave HI/LO alone.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } md_result_t;

    function automatic logic op_is_mult(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic md_result_t md_compute(input logic [2:0]      op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        md_result_t            res;
        logic signed [2*XLEN-1:0] prod_s;
        logic [2*XLEN-1:0]     prod_u;
        logic [XLEN-1:0]       mag_a;
        logic [XLEN-1:0]       mag_b;
        logic [XLEN-1:0]       q_u;
        logic [XLEN-1:0]       r_u;
        logic                  sgn;

        res    = '0;
        prod_s = '0;
        prod_u = '0;
        mag_a  = '0;
        mag_b  = '0;
        q_u    = '0;
        r_u    = '0;
        sgn    = 1'b0;

        case (op)
            MD_MULT: begin
                prod_s    = $signed({{XLEN{a[XLEN-1]}}, a}) * $signed({{XLEN{b[XLEN-1]}}, b});
                res.valid = 1'b1;
                res.hi    = prod_s[2*XLEN-1:XLEN];
                res.lo    = prod_s[XLEN-1:0];
            end
            MD_MULTU: begin
                prod_u    = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
                res.valid = 1'b1;
                res.hi    = prod_u[2*XLEN-1:XLEN];
                res.lo    = prod_u[XLEN-1:0];
            end
            MD_DIV: begin
                // Divide magnitudes, then restore signs; -2^31 / -1 wraps to -2^31.
                if (b != '0) begin
                    sgn       = a[XLEN-1] ^ b[XLEN-1];
                    mag_a     = a[XLEN-1] ? (~a + XLEN'(1)) : a;
                    mag_b     = b[XLEN-1] ? (~b + XLEN'(1)) : b;
                    q_u       = mag_a / mag_b;
                    r_u       = mag_a % mag_b;
                    res.valid = 1'b1;
                    res.lo    = sgn ? (~q_u + XLEN'(1)) : q_u;
                    res.hi    = a[XLEN-1] ? (~r_u + XLEN'(1)) : r_u;
                end
            end
            MD_DIVU: begin
                if (b != '0) begin
                    res.valid = 1'b1;
                    res.lo    = a / b;
                    res.hi    = a % b;
                end
            end
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO: fixed-latency MULT/DIV with a busy window for the
// hazard unit, plus zero-latency MTHI/MTLO writes when idle.
module md_unit
    import md_defs::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      md_op,
    input  logic            wr_hilo,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES - 1);

    md_state_e        r_state;
    md_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    md_result_t       r_pend;
    logic [XLEN-1:0]  r_hi;
    logic [XLEN-1:0]  r_lo;
    logic             r_busy;

    logic w_start_ok;
    logic w_load;
    logic w_dec;
    logic w_commit;
    logic w_wr_hi;
    logic w_wr_lo;

    assign w_start_ok = start && (md_op <= 3'(MD_DIVU));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_state_nxt = S_BUSY;
            S_BUSY:  if (r_cnt == '0) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Control outputs; start outranks wr_hilo, and both are dropped while busy
    always_comb begin
        w_load   = 1'b0;
        w_dec    = 1'b0;
        w_commit = 1'b0;
        w_wr_hi  = 1'b0;
        w_wr_lo  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_load  = w_start_ok;
                w_wr_hi = wr_hilo && !start && (md_op == 3'(MD_MTHI));
                w_wr_lo = wr_hilo && !start && (md_op == 3'(MD_MTLO));
            end
            S_BUSY: begin
                w_dec    = (r_cnt != '0);
                w_commit = (r_cnt == '0);
            end
            default: ;
        endcase
    end

    // Pending result and latency counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend <= '0;
            r_cnt  <= '0;
        end else if (w_load) begin
            r_pend <= md_compute(md_op, a, b);
            r_cnt  <= op_is_mult(md_op) ? MULT_CNT : DIV_CNT;
        end else if (w_dec) begin
            r_cnt  <= r_cnt - CNT_W'(1);
        end
    end

    // Architectural HI/LO and busy flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_busy <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == S_BUSY);
            if (w_commit && r_pend.valid) begin
                r_hi <= r_pend.hi;
                r_lo <= r_pend.lo;
            end
            if (w_wr_hi) r_hi <= a;
            if (w_wr_lo) r_lo <= a;
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
